// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiply and restoring divide, one bit per cycle
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;
  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc, mul_acc, rem_n, quo_n;
  logic [WIDTH:0]   rem_sh;
  logic [CW-1:0]    cnt;
  logic             ge;
  // one iteration step: multiplier accumulate, and restoring-divide trial subtraction
  always_comb begin
    mul_acc = b_q[0] ? acc + a_q : acc;
    rem_sh  = {acc, a_q[WIDTH-1]};
    ge      = rem_sh >= {1'b0, b_q};
    rem_n   = ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
    quo_n   = {a_q[WIDTH-2:0], ge};
  end
  assign stall = (state == IDLE && start && !flush) || state == BUSY;
  // sequencer; a_q doubles as multiplicand or dividend/quotient shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q <= op;
            a_q  <= operand_a;
            b_q  <= operand_b;
            acc  <= '0;
            cnt  <= CW'(WIDTH - 1);
            busy <= 1'b1;
            if (op == 2'b11 || ((op == 2'b01 || op == 2'b10) && operand_b == '0)) begin
              result <= op == 2'b01 ? '1 : op == 2'b10 ? operand_a : '0;
              done   <= 1'b1;
              state  <= FIN;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= op_q == 2'b00 ? mul_acc : rem_n;
          a_q <= op_q == 2'b00 ? a_q << 1 : quo_n;
          b_q <= op_q == 2'b00 ? b_q >> 1 : b_q;
          if (cnt == '0) begin
            result <= op_q == 2'b00 ? mul_acc : op_q == 2'b01 ? quo_n : rem_n;
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench checking results, latency, flush and reset behaviour
module tb_muldiv_sequencer;
  logic        clk = 0, reset = 1, start = 0, flush = 0, stall, done, busy;
  logic [1:0]  op = 0;
  logic [31:0] operand_a = 0, operand_b = 0, result;
  typedef struct {logic [31:0] res; int lat; int t;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_checks = 0, n_fail = 0, cyc = 0, stall_cnt = 0, last_t = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
    .operand_a(operand_a), .operand_b(operand_b),
    .stall(stall), .done(done), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'b00: return p[31:0];
      2'b01: return b == 0 ? 32'hFFFF_FFFF : a / b;
      2'b10: return b == 0 ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (!reset && done) begin
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", 64'(cyc - e.t), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1; op = o; operand_a = a; operand_b = b;
    #1 check("stall_accept", stall, 1);
    @(posedge clk); #1;
    start = 0;
    last_t = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 0);
      sb.delete();
    end
    #1;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    exp_t x;
    issue(o, a, b);
    x.res = exp;
    x.lat = (o == 2'b11 || (o != 2'b00 && b == 0)) ? 0 : 32;
    x.t = last_t;
    check("model", model(o, a, b), exp);
    sb.push_back(x);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    stall_cnt = 0;
    do_op(2'b00, 7, 6, 42);
    check("busy_mid", busy, 1);
    wait_done();
    check("stall_cycles", 64'(stall_cnt), 33);
    check("busy_after", busy, 0);
    do_op(2'b00, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE); wait_done();
    do_op(2'b01, 100, 7, 14); wait_done();
    do_op(2'b10, 100, 7, 2); wait_done();
    do_op(2'b01, 5, 9, 0); wait_done();
    do_op(2'b01, 123, 0, 32'hFFFF_FFFF); wait_done();
    do_op(2'b11, 55, 66, 0); wait_done();
    do_op(2'b10, 123, 0, 123); wait_done();
    // flush at BUSY cycle 10 of DIVU 100/7
    issue(2'b01, 100, 7);
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    check("flush_busy", busy, 0);
    check("flush_stall", stall, 0);
    check("flush_done", done, 0);
    repeat (40) @(posedge clk);
    #1 check("flush_result", result, 123);
    // flush together with start in IDLE: nothing accepted
    start = 1; flush = 1; op = 2'b00; operand_a = 5; operand_b = 5;
    #1 check("flush_start_stall", stall, 0);
    @(posedge clk); #1 start = 0; flush = 0;
    check("flush_start_busy", busy, 0);
    do_op(2'b00, 3, 4, 12); wait_done();
    // start during BUSY is ignored
    do_op(2'b00, 7, 6, 42);
    repeat (4) @(posedge clk);
    #1 start = 1; op = 2'b00; operand_a = 9; operand_b = 9;
    @(posedge clk); #1 start = 0;
    wait_done();
    repeat (40) @(posedge clk);
    // reset at BUSY cycle 20
    issue(2'b10, 32'h1234, 3);
    repeat (19) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    do_op(2'b10, 32'hFFFF_FFFF, 16, 15); wait_done();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op(o, a, b, model(o, a, b));
      wait_done();
    end
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
